// File: rtl/pack_fsm_if.sv
// Bus bundle for pack_fsm: input-buffer write port, output-buffer read port,
// run control and run status.
interface pack_fsm_if #(
    parameter int DATA_W   = 8,
    parameter int PACK     = 2,
    parameter int IN_DEPTH = 32
);
    localparam int OUT_DEPTH = IN_DEPTH / PACK;
    localparam int AW_IN     = $clog2(IN_DEPTH);
    localparam int AW_OUT    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic                     wr_en;
    logic [AW_IN-1:0]         wr_add;
    logic [DATA_W-1:0]        data_wr;
    logic [AW_OUT-1:0]        rd_add;
    logic                     start;
    logic                     msb_first;
    logic [DATA_W*PACK-1:0]   data_out;
    logic                     busy;
    logic                     done;

    modport master (
        output wr_en, wr_add, data_wr, rd_add, start, msb_first,
        input  data_out, busy, done
    );

    modport slave (
        input  wr_en, wr_add, data_wr, rd_add, start, msb_first,
        output data_out, busy, done
    );
endinterface

// File: rtl/pack_fsm.sv
// Packs every PACK consecutive words of an input buffer into one wide word of an
// output buffer; packing order (MSB- or LSB-first) is latched at run start.
module pack_fsm #(
    parameter int DATA_W   = 8,
    parameter int PACK     = 2,
    parameter int IN_DEPTH = 32
) (
    input logic       clk,
    input logic       rst,
    pack_fsm_if.slave bus
);
    localparam int OUT_DEPTH = IN_DEPTH / PACK;
    localparam int AW_IN     = $clog2(IN_DEPTH);
    localparam int AW_OUT    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int KW        = $clog2(PACK);
    localparam int OW        = DATA_W * PACK;

    typedef enum logic {ST_IDLE, ST_PACK} state_t;

    state_t            state_reg, state_next;
    logic [AW_IN-1:0]  ptr_reg, ptr_next;
    logic [KW-1:0]     slot_reg, slot_next;
    logic [AW_OUT-1:0] wptr_reg, wptr_next;
    logic              mode_reg, mode_next;
    logic              done_reg, done_next;
    logic [OW-1:0]     acc_reg, acc_next;
    logic [OW-1:0]     data_out_reg;
    logic              in_we, out_we;
    logic [DATA_W-1:0] cur_word;

    logic [DATA_W-1:0] in_mem  [IN_DEPTH];
    logic [OW-1:0]     out_mem [OUT_DEPTH];

    assign cur_word = in_mem[ptr_reg];
    assign in_we    = bus.wr_en && (state_reg == ST_IDLE);

    // Physical slice gi (counted from the LS end) takes the current word when the
    // group position maps onto it under the latched order; others hold.
    generate
        for (genvar gi = 0; gi < PACK; gi++) begin : g_slice
            logic hit;
            assign hit = mode_reg ? (slot_reg == KW'(PACK - 1 - gi))
                                  : (slot_reg == KW'(gi));
            assign acc_next[gi*DATA_W +: DATA_W] =
                hit ? cur_word : acc_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        slot_next  = slot_reg;
        wptr_next  = wptr_reg;
        mode_next  = mode_reg;
        done_next  = done_reg;
        out_we     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_PACK;
                    ptr_next   = '0;
                    slot_next  = '0;
                    wptr_next  = '0;
                    mode_next  = bus.msb_first;
                    done_next  = 1'b0;
                end
            end
            ST_PACK: begin
                ptr_next = ptr_reg + 1'b1;
                if (slot_reg == KW'(PACK - 1)) begin
                    slot_next = '0;
                    out_we    = 1'b1;
                    wptr_next = wptr_reg + 1'b1;
                end else begin
                    slot_next = slot_reg + 1'b1;
                end
                if (ptr_reg == AW_IN'(IN_DEPTH - 1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            slot_reg  <= '0;
            wptr_reg  <= '0;
            mode_reg  <= 1'b0;
            done_reg  <= 1'b0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            slot_reg  <= slot_next;
            wptr_reg  <= wptr_next;
            mode_reg  <= mode_next;
            done_reg  <= done_next;
            if (state_reg == ST_PACK) begin
                acc_reg <= acc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IN_DEPTH; i++) begin
                in_mem[i] <= '0;
            end
        end else if (in_we) begin
            in_mem[bus.wr_add] <= bus.data_wr;
        end
    end

    // The group's last word goes straight from acc_next so it lands in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                out_mem[i] <= '0;
            end
            data_out_reg <= '0;
        end else begin
            if (out_we) begin
                out_mem[wptr_reg] <= acc_next;
            end
            data_out_reg <= out_mem[bus.rd_add];
        end
    end

    assign bus.data_out = data_out_reg;
    assign bus.busy     = (state_reg == ST_PACK);
    assign bus.done     = done_reg;
endmodule

// File: tb/tb_pack_fsm.sv
// Randomised scoreboard bench for pack_fsm: default instance against a buffer-level
// reference model, plus a wide (PACK=4) instance against fixed expected words.
module tb_pack_fsm;
    localparam int DW = 8;
    localparam int P  = 2;
    localparam int D  = 32;
    localparam int OD = D / P;
    localparam int WP = 4;
    localparam int WD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pack_fsm_if #(.DATA_W(DW), .PACK(P),  .IN_DEPTH(D))  bus  ();
    pack_fsm_if #(.DATA_W(DW), .PACK(WP), .IN_DEPTH(WD)) wbus ();

    pack_fsm #(.DATA_W(DW), .PACK(P),  .IN_DEPTH(D))  dut   (.clk(clk), .rst(rst), .bus(bus));
    pack_fsm #(.DATA_W(DW), .PACK(WP), .IN_DEPTH(WD)) dut_w (.clk(clk), .rst(rst), .bus(wbus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          busy;
        bit          done;
        bit          has_rd;
        logic [63:0] rd;
    } exp_t;

    // Reference model: buffer contents, run cycles remaining, done flag, latched order
    logic [DW-1:0]   m_in  [D];
    logic [DW*P-1:0] m_out [OD];
    int              run_left = 0;
    bit              m_done   = 1'b0;
    bit              m_mode   = 1'b0;
    bit              rd_req   = 1'b0;
    bit              rd_fix   = 1'b0;
    logic [63:0]     rd_fix_val = '0;
    exp_t            q [$];

    int              wm_left = 0;
    bit              wm_done = 1'b0;
    bit              wrd_req = 1'b0;
    logic [63:0]     wrd_val = '0;
    exp_t            qw [$];

    // Lowest address of each group lands in the MS slice when msb-first
    task automatic finish_run();
        for (int w = 0; w < OD; w++) begin
            logic [DW*P-1:0] word;
            word = '0;
            for (int j = 0; j < P; j++) begin
                int slot;
                slot = m_mode ? (P - 1 - j) : j;
                word[slot*DW +: DW] = m_in[w*P + j];
            end
            m_out[w] = word;
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        e.has_rd = rd_req;
        if (rst)         e.rd = 64'd0;
        else if (rd_fix) e.rd = rd_fix_val;
        else             e.rd = 64'(m_out[bus.rd_add]);
        if (rst) begin
            for (int i = 0; i < D; i++)  m_in[i]  = '0;
            for (int i = 0; i < OD; i++) m_out[i] = '0;
            run_left = 0;
            m_done   = 1'b0;
        end else if (run_left > 0) begin
            run_left--;
            if (run_left == 0) begin
                finish_run();
                m_done = 1'b1;
            end
        end else begin
            if (bus.wr_en) m_in[bus.wr_add] = bus.data_wr;
            if (bus.start) begin
                run_left = D;
                m_mode   = bus.msb_first;
                m_done   = 1'b0;
            end
        end
        e.busy = (run_left > 0);
        e.done = m_done;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wstep();
        exp_t e;
        @(posedge clk);
        e.has_rd = wrd_req;
        e.rd     = rst ? 64'd0 : wrd_val;
        if (rst) begin
            wm_left = 0;
            wm_done = 1'b0;
        end else if (wm_left > 0) begin
            wm_left--;
            if (wm_left == 0) wm_done = 1'b1;
        end else if (wbus.start) begin
            wm_left = WD;
            wm_done = 1'b0;
        end
        e.busy = (wm_left > 0);
        e.done = wm_done;
        qw.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("busy", 64'(bus.busy), 64'(e.busy));
                chk("done", 64'(bus.done), 64'(e.done));
                if (e.has_rd) chk("data_out", 64'(bus.data_out), e.rd);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (qw.size() > 0) begin
                e = qw.pop_front();
                chk("wide_busy", 64'(wbus.busy), 64'(e.busy));
                chk("wide_done", 64'(wbus.done), 64'(e.done));
                if (e.has_rd) chk("wide_data_out", 64'(wbus.data_out), e.rd);
            end
        end
    end

    task automatic fill(input int kind);
        for (int i = 0; i < D; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_add  = 5'(i);
            bus.data_wr = (kind == 0) ? 8'(2*i + 1) : (kind == 1) ? 8'(i) : 8'($urandom);
            step();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic start_run(input bit m);
        bus.start     = 1'b1;
        bus.msb_first = m;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_run();
        for (int n = 0; n < 200 && run_left > 0; n++) step();
    endtask

    task automatic read_fix(input int a, input logic [63:0] v);
        rd_req = 1'b1; rd_fix = 1'b1; rd_fix_val = v;
        bus.rd_add = 4'(a);
        step();
        rd_req = 1'b0; rd_fix = 1'b0;
    endtask

    task automatic read_all();
        for (int w = 0; w < OD; w++) begin
            rd_req = 1'b1;
            bus.rd_add = 4'(w);
            step();
        end
        rd_req = 1'b0;
    endtask

    task automatic wread_fix(input int a, input logic [63:0] v);
        wrd_req = 1'b1; wrd_val = v;
        wbus.rd_add = 2'(a);
        wstep();
        wrd_req = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_add = '0; bus.data_wr = '0;
        bus.rd_add = '0; bus.start = 1'b0; bus.msb_first = 1'b0;
        wbus.wr_en = 1'b0; wbus.wr_add = '0; wbus.data_wr = '0;
        wbus.rd_add = '0; wbus.start = 1'b0; wbus.msb_first = 1'b0;
        for (int i = 0; i < D; i++)  m_in[i]  = '0;
        for (int i = 0; i < OD; i++) m_out[i] = '0;

        // Reset state
        rst = 1'b1; rd_req = 1'b1;
        step(); step();
        rst = 1'b0; rd_req = 1'b0;
        read_all();

        // MSB-first then LSB-first on the 2i+1 fill
        fill(0);
        start_run(1'b1);
        wait_run();
        read_fix(0, 64'h0103);
        read_fix(15, 64'h3D3F);
        read_all();
        start_run(1'b0);
        wait_run();
        read_fix(0, 64'h0301);
        read_fix(15, 64'h3F3D);

        // Write and start while busy are ignored
        start_run(1'b1);
        repeat (5) step();
        bus.wr_en = 1'b1; bus.wr_add = 5'd0; bus.data_wr = 8'hFF;
        bus.start = 1'b1; bus.msb_first = 1'b0;
        step();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        wait_run();
        read_fix(0, 64'h0103);
        start_run(1'b1);
        wait_run();
        read_fix(0, 64'h0103);

        // Reset at cycle 10 of a run, then a fresh random run
        start_run(1'b0);
        repeat (9) step();
        rst = 1'b1; rd_req = 1'b1;
        step();
        rst = 1'b0; rd_req = 1'b0;
        read_all();
        fill(2);
        start_run(1'($urandom_range(0, 1)));
        wait_run();
        read_all();

        // Done stays set while idle; restart with the i fill
        repeat (20) step();
        fill(1);
        start_run(1'b1);
        wait_run();
        read_fix(1, 64'h0203);
        read_all();

        // Random partial refills with random traffic during the run
        repeat (4) begin
            for (int i = 0; i < 12; i++) begin
                bus.wr_en   = 1'b1;
                bus.wr_add  = 5'($urandom_range(0, D - 1));
                bus.data_wr = 8'($urandom);
                step();
            end
            bus.wr_en = 1'b0;
            start_run(1'($urandom_range(0, 1)));
            for (int n = 0; n < 200 && run_left > 0; n++) begin
                bus.wr_en     = 1'($urandom_range(0, 1));
                bus.wr_add    = 5'($urandom_range(0, D - 1));
                bus.data_wr   = 8'($urandom);
                bus.start     = 1'($urandom_range(0, 1));
                bus.msb_first = 1'($urandom_range(0, 1));
                step();
            end
            bus.wr_en = 1'b0; bus.start = 1'b0;
            read_all();
        end

        // Wide instance: PACK=4, IN_DEPTH=16, msb-first
        for (int i = 0; i < WD; i++) begin
            wbus.wr_en   = 1'b1;
            wbus.wr_add  = 4'(i);
            wbus.data_wr = 8'(2*i + 1);
            wstep();
        end
        wbus.wr_en = 1'b0;
        wbus.start = 1'b1; wbus.msb_first = 1'b1;
        wstep();
        wbus.start = 1'b0;
        for (int n = 0; n < 100 && wm_left > 0; n++) wstep();
        wread_fix(0, 64'h01030507);
        wread_fix(3, 64'h191B1D1F);

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
